// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer (+ control_sequencer_pkg)
// Brief    : SAP-2 instruction fetch sequencer and microcode decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

    localparam logic [15:0] RESET_VECTOR = 16'hF000;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_HLT   = 8'h01,
        OP_JMP   = 8'h10,
        OP_LDA   = 8'hA0,
        OP_LDI_A = 8'hB0,
        OP_LDI_B = 8'hB1,
        OP_LDI_C = 8'hB2
    } opcode_t;

    typedef enum logic [2:0] {
        S_RESET          = 3'd0,
        S_INIT           = 3'd1,
        S_LATCH_ADDR     = 3'd2,
        S_READ_BYTE      = 3'd3,
        S_LATCH_BYTE     = 3'd4,
        S_CHK_MORE_BYTES = 3'd5,
        S_EXECUTE        = 3'd6,
        S_HALT           = 3'd7
    } fsm_state_t;

    typedef enum logic [3:0] {
        MS0 = 4'd0, MS1 = 4'd1, MS2 = 4'd2, MS3 = 4'd3,
        MS4 = 4'd4, MS5 = 4'd5, MS6 = 4'd6, MS7 = 4'd7
    } microstep_t;

    typedef struct packed {
        logic load_origin;
        logic load_mar_pc;
        logic oe_ram;
        logic pc_enable;
        logic load_ir;
        logic load_temp_1;
        logic load_temp_2;
        logic oe_temp_1;
        logic oe_temp_2;
        logic load_pc_low_byte;
        logic load_pc_high_byte;
        logic load_mar_addr_low;
        logic load_mar_addr_high;
        logic load_a;
        logic load_b;
        logic load_c;
        logic load_flags;
        logic load_sets_zn;
        logic halt;
        logic last_step;
    } control_word_t;

endpackage

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MAX_INSTR_BYTES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    opcode_in,
    output control_word_t control_word,
    output logic [2:0]    state_out,
    output logic [3:0]    microstep_out,
    output logic          halted
);

    localparam int c_IDX_W = $clog2(MAX_INSTR_BYTES + 1);

    fsm_state_t           r_state, w_state_nxt;
    microstep_t           r_ms, w_ms_nxt;
    logic [c_IDX_W-1:0]   r_byte_idx, w_byte_idx_nxt;
    logic [c_IDX_W-1:0]   w_len;
    control_word_t        w_ucode;
    control_word_t        w_cw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RESET;
            r_ms       <= MS0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ms       <= w_ms_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

    // Instruction length; anything unrecognised is a one-byte NOP.
    always_comb begin
        w_len = c_IDX_W'(1);
        case (opcode_in)
            OP_JMP, OP_LDA:                w_len = c_IDX_W'(3);
            OP_LDI_A, OP_LDI_B, OP_LDI_C:  w_len = c_IDX_W'(2);
            default:                       w_len = c_IDX_W'(1);
        endcase
    end

    always_comb begin
        w_ucode = '0;
        case (opcode_in)
            OP_HLT: begin
                w_ucode.halt      = 1'b1;
                w_ucode.last_step = 1'b1;
            end
            OP_JMP: begin
                if (r_ms == MS0) begin
                    w_ucode.oe_temp_1        = 1'b1;
                    w_ucode.load_pc_low_byte = 1'b1;
                end else if (r_ms == MS1) begin
                    w_ucode.oe_temp_2         = 1'b1;
                    w_ucode.load_pc_high_byte = 1'b1;
                    w_ucode.last_step         = 1'b1;
                end
            end
            OP_LDA: begin
                case (r_ms)
                    MS0: begin
                        w_ucode.oe_temp_1         = 1'b1;
                        w_ucode.load_mar_addr_low = 1'b1;
                    end
                    MS1: begin
                        w_ucode.oe_temp_2          = 1'b1;
                        w_ucode.load_mar_addr_high = 1'b1;
                    end
                    MS2: w_ucode.oe_ram = 1'b1;
                    MS3: begin
                        w_ucode.oe_ram       = 1'b1;
                        w_ucode.load_a       = 1'b1;
                        w_ucode.load_flags   = 1'b1;
                        w_ucode.load_sets_zn = 1'b1;
                        w_ucode.last_step    = 1'b1;
                    end
                    default: w_ucode = '0;
                endcase
            end
            OP_LDI_A: begin
                w_ucode.oe_temp_1    = 1'b1;
                w_ucode.load_a       = 1'b1;
                w_ucode.load_flags   = 1'b1;
                w_ucode.load_sets_zn = 1'b1;
                w_ucode.last_step    = 1'b1;
            end
            OP_LDI_B: begin
                w_ucode.oe_temp_1 = 1'b1;
                w_ucode.load_b    = 1'b1;
                w_ucode.last_step = 1'b1;
            end
            OP_LDI_C: begin
                w_ucode.oe_temp_1 = 1'b1;
                w_ucode.load_c    = 1'b1;
                w_ucode.last_step = 1'b1;
            end
            default: w_ucode.last_step = 1'b1;
        endcase
        // A runaway microprogram is always terminated at the last microstep.
        if (r_ms == MS7) begin
            w_ucode.last_step = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ms_nxt       = r_ms;
        w_byte_idx_nxt = r_byte_idx;
        w_cw           = '0;
        case (r_state)
            S_RESET: w_state_nxt = S_INIT;
            S_INIT: begin
                w_cw.load_origin = 1'b1;
                w_byte_idx_nxt   = '0;
                w_state_nxt      = S_LATCH_ADDR;
            end
            S_LATCH_ADDR: begin
                w_cw.load_mar_pc = 1'b1;
                w_state_nxt      = S_READ_BYTE;
            end
            S_READ_BYTE: begin
                w_cw.oe_ram = 1'b1;
                w_state_nxt = S_LATCH_BYTE;
            end
            S_LATCH_BYTE: begin
                w_cw.oe_ram    = 1'b1;
                w_cw.pc_enable = 1'b1;
                if (r_byte_idx == '0) begin
                    w_cw.load_ir = 1'b1;
                end else if (r_byte_idx == c_IDX_W'(1)) begin
                    w_cw.load_temp_1 = 1'b1;
                end else begin
                    w_cw.load_temp_2 = 1'b1;
                end
                w_byte_idx_nxt = r_byte_idx + c_IDX_W'(1);
                w_state_nxt    = S_CHK_MORE_BYTES;
            end
            S_CHK_MORE_BYTES: begin
                if (r_byte_idx < w_len) begin
                    w_state_nxt = S_LATCH_ADDR;
                end else begin
                    w_ms_nxt    = MS0;
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                w_cw = w_ucode;
                if (w_ucode.halt) begin
                    w_state_nxt = S_HALT;
                end else if (w_ucode.last_step) begin
                    w_byte_idx_nxt = '0;
                    w_ms_nxt       = MS0;
                    w_state_nxt    = S_LATCH_ADDR;
                end else begin
                    w_ms_nxt = microstep_t'(r_ms + 4'd1);
                end
            end
            S_HALT: w_cw.halt = 1'b1;
            default: w_state_nxt = S_RESET;
        endcase
    end

    assign control_word  = w_cw;
    assign state_out     = r_state;
    assign microstep_out = r_ms;
    assign halted        = (r_state == S_HALT);

endmodule

`default_nettype wire
